port_bcd_conv: RTL and testbench
================================

PORT_BCD_CONV -- requirements
Module: port_bcd_conv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 value  input  32  binary output-port word from the MEM stage (out_port0/1/2).
REQ-005 bcd  output  20  five packed BCD digits, [3:0]=ones .. [19:16]=ten-thousands.
REQ-006 ovf  output  1  last converted word was >= 100 (does not fit the two-digit display).
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 valid  output  1  one-cycle pulse when bcd/ovf update.

Function
REQ-009 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-010 In IDLE, on an edge where value != last_value, the block SHALL latch value into last_value and a 16-bit shift register (value[15:0]), clear a 20-bit scratch BCD, set count=0 and go to SHIFT.
REQ-011 In IDLE, with value == last_value, the block SHALL stay in IDLE and hold all outputs.
REQ-012 Each SHIFT cycle SHALL do one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, shreg} left by 1.
REQ-013 After the 16th SHIFT step (count==15), the FSM SHALL go to DONE.
REQ-014 DONE SHALL last one cycle, load bcd from the scratch register and ovf = (last_value >= 100), assert valid and return to IDLE.
REQ-015 Latency SHALL be fixed: bcd/valid update on the 18th rising edge after the edge that samples a changed value.
REQ-016 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-017 bcd and ovf SHALL change only in DONE, never with partial results.
REQ-018 Changes to value during SHIFT/DONE SHALL be ignored; on return to IDLE the block SHALL compare against the latched last_value and restart if they differ, so the final stable value is always converted.
REQ-019 value[31:16] != 0 SHALL force ovf=1; bcd SHALL show the conversion of value[15:0] only (modulo 65536).
REQ-020 The block SHALL NOT drop a conversion when value returns to last_value mid-conversion; no restart occurs.

Reset
REQ-021 While resetn is low, state=IDLE, last_value=0, bcd=0, ovf=0, busy=0, valid=0, count=0, and scratch/shift registers=0.
REQ-022 An assertion of reset mid-conversion SHALL abort it with no valid pulse; after release, a nonzero value SHALL start a fresh conversion.
REQ-023 After reset, value=0 SHALL start no conversion; bcd=0 is already correct.

Configuration
REQ-024 Macro OVERFLOW_BLANK_EN: when it is defined, DONE with ovf=1 SHALL load bcd=20'hFFFFF, so the seven-segment decoders blank all digits.
REQ-025 When OVERFLOW_BLANK_EN is undefined, bcd SHALL always carry the real conversion, and ovf is only a flag.

Verification
REQ-026 Reset, then value=42 -> 18 edges later bcd=20'h00042, ovf=0, one valid pulse, busy high for 17 cycles.
REQ-027 value=65535 -> bcd=20'h65535, ovf=1; with OVERFLOW_BLANK_EN, bcd=20'hFFFFF.
REQ-028 value=32'h0001_0005 -> bcd=20'h00005, ovf=1 (macro off).
REQ-029 value=12, changed to 34 on the 5th SHIFT cycle -> first valid with bcd=20'h00012, then a second conversion with bcd=20'h00034; exactly two valid pulses.
REQ-030 value=99 then resetn pulsed low on the 8th SHIFT cycle -> all outputs 0 and no valid pulse; after release, bcd=20'h00099 18 edges later.
REQ-031 value held constant for 100 cycles after a conversion -> no further valid pulses, busy=0.

Source files
------------

// File: rtl/port_bcd_conv.sv
// port_bcd_conv: converts the binary output-port word into five packed BCD
// digits for the seven-segment display, using a sequential double-dabble
// (one shift per clock, 16 shifts per word).
// Optional feature: define OVERFLOW_BLANK_EN to load bcd with all-ones
// (blanked digits) whenever the converted word does not fit in two digits.
module port_bcd_conv (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] value,
    output logic [19:0] bcd,
    output logic        ovf,
    output logic        busy,
    output logic        valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_value_q;     // sampled copy of the input word
    logic [31:0] r_last_value;  // word currently / last converted
    logic [15:0] r_shreg;
    logic [19:0] r_scratch;
    logic [3:0]  r_count;
    logic [19:0] r_bcd;
    logic        r_ovf;
    logic        r_busy;
    logic        r_valid;

    logic [19:0] w_adj;
    logic        w_ovf;
    logic [19:0] w_done_bcd;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more,
    // so the following left shift carries correctly into the next digit.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int d = 0; d < 5; d++) begin
            if (r[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Digit correction for the current step and the overflow / display value
    // presented when the conversion completes.
    always_comb begin
        w_adj = dabble_adjust(r_scratch);
        w_ovf = (r_last_value >= 32'd100);
`ifdef OVERFLOW_BLANK_EN
        w_done_bcd = w_ovf ? 20'hFFFFF : r_scratch;
`else
        w_done_bcd = r_scratch;
`endif
    end

    // Input sampling register; the FSM compares this copy against the
    // latched word, which also keeps the input path off the FSM logic.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_value_q <= 32'd0;
        end else begin
            r_value_q <= value;
        end
    end

    // Conversion FSM with registered outputs. Input changes while busy are
    // ignored; back in IDLE the sampled word is compared again, so the final
    // stable value is always converted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_last_value <= 32'd0;
            r_shreg      <= 16'd0;
            r_scratch    <= 20'd0;
            r_count      <= 4'd0;
            r_bcd        <= 20'd0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (r_value_q != r_last_value) begin
                        r_last_value <= r_value_q;
                        r_shreg      <= r_value_q[15:0];
                        r_scratch    <= 20'd0;
                        r_count      <= 4'd0;
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_valid                <= 1'b0;
                    {r_scratch, r_shreg}   <= {w_adj[18:0], r_shreg, 1'b0};
                    r_count                <= r_count + 4'd1;
                    if (r_count == 4'd15) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd   <= w_done_bcd;
                    r_ovf   <= w_ovf;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd   = r_bcd;
    assign ovf   = r_ovf;
    assign busy  = r_busy;
    assign valid = r_valid;

endmodule

// File: tb/tb_port_bcd_conv.sv
// Directed testbench for port_bcd_conv: reset state, conversion latency,
// busy length, valid pulse count, overflow handling, mid-conversion input
// changes, mid-conversion reset and idle hold behaviour.
module tb_port_bcd_conv;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] value;
    logic [19:0] bcd;
    logic        ovf;
    logic        busy;
    logic        valid;

    int errors = 0;
    int checks = 0;

`ifdef OVERFLOW_BLANK_EN
    localparam logic [19:0] EXP_65535 = 20'hFFFFF;
    localparam logic [19:0] EXP_10005 = 20'hFFFFF;
    localparam logic [19:0] EXP_100   = 20'hFFFFF;
`else
    localparam logic [19:0] EXP_65535 = 20'h65535;
    localparam logic [19:0] EXP_10005 = 20'h00005;
    localparam logic [19:0] EXP_100   = 20'h00100;
`endif

    port_bcd_conv dut (
        .clock  (clock),
        .resetn (resetn),
        .value  (value),
        .bcd    (bcd),
        .ovf    (ovf),
        .busy   (busy),
        .valid  (valid)
    );

    always #5 clock = ~clock;

    // Watchdog: the run is short, so this only fires if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Must be called right after a falling edge. Drives v, then samples
    // 'budget' falling edges; sample i follows rising edge i, where edge 0 is
    // the one that samples v. Records first valid index, busy and valid counts.
    task automatic run_value(input logic [31:0] v, input int budget,
                             output int lat, output int busy_cnt, output int vld_cnt,
                             output logic [19:0] bcd_at, output logic ovf_at,
                             output logic early);
        logic [19:0] prev;
        value    = v;
        lat      = -1;
        busy_cnt = 0;
        vld_cnt  = 0;
        bcd_at   = 20'd0;
        ovf_at   = 1'b0;
        early    = 1'b0;
        prev     = bcd;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (valid === 1'b1) begin
                vld_cnt++;
                if (lat < 0) begin
                    lat    = i;
                    bcd_at = bcd;
                    ovf_at = ovf;
                end
            end else if (bcd !== prev) begin
                early = 1'b1;
            end
            prev = bcd;
        end
    endtask

    task automatic test_reset;
        int lat, bc, vc;
        logic [19:0] b;
        logic o, e;
        resetn = 1'b0;
        value  = 32'd0;
        repeat (3) @(negedge clock);
        checks++; if (bcd !== 20'd0) begin errors++; $display("FAIL reset_bcd: got %h want %h", bcd, 20'd0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        resetn = 1'b1;
        run_value(32'd0, 30, lat, bc, vc, b, o, e);
        checks++; if (vc !== 0) begin errors++; $display("FAIL zero_after_reset_valid: got %0d pulses want 0", vc); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL zero_after_reset_busy: got %0d cycles want 0", bc); end
    endtask

    task automatic test_basic;
        int lat, bc, vc;
        logic [19:0] b;
        logic o, e;
        @(negedge clock);
        run_value(32'd42, 40, lat, bc, vc, b, o, e);
        checks++; if (lat !== 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", lat); end
        checks++; if (bc !== 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
        checks++; if (vc !== 1) begin errors++; $display("FAIL basic_valid_pulses: got %0d want 1", vc); end
        checks++; if (b !== 20'h00042) begin errors++; $display("FAIL basic_bcd: got %h want %h", b, 20'h00042); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", o); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_partial_bcd: got %b want 0", e); end
    endtask

    task automatic test_overflow;
        int lat, bc, vc;
        logic [19:0] b;
        logic o, e;
        @(negedge clock);
        run_value(32'd65535, 40, lat, bc, vc, b, o, e);
        checks++; if (lat !== 18) begin errors++; $display("FAIL max_latency: got %0d want 18", lat); end
        checks++; if (b !== EXP_65535) begin errors++; $display("FAIL max_bcd: got %h want %h", b, EXP_65535); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL max_ovf: got %b want 1", o); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL max_partial_bcd: got %b want 0", e); end
    endtask

    task automatic test_upper_bits;
        int lat, bc, vc;
        logic [19:0] b;
        logic o, e;
        @(negedge clock);
        run_value(32'h0001_0005, 40, lat, bc, vc, b, o, e);
        checks++; if (vc !== 1) begin errors++; $display("FAIL upper_valid_pulses: got %0d want 1", vc); end
        checks++; if (b !== EXP_10005) begin errors++; $display("FAIL upper_bcd: got %h want %h", b, EXP_10005); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL upper_ovf: got %b want 1", o); end
    endtask

    task automatic test_boundary;
        int lat, bc, vc;
        logic [19:0] b;
        logic o, e;
        @(negedge clock);
        run_value(32'd100, 40, lat, bc, vc, b, o, e);
        checks++; if (b !== EXP_100) begin errors++; $display("FAIL b100_bcd: got %h want %h", b, EXP_100); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL b100_ovf: got %b want 1", o); end
        run_value(32'd99, 40, lat, bc, vc, b, o, e);
        checks++; if (b !== 20'h00099) begin errors++; $display("FAIL b99_bcd: got %h want %h", b, 20'h00099); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL b99_ovf: got %b want 0", o); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL b99_latency: got %0d want 18", lat); end
    endtask

    task automatic test_mid_change;
        int vc;
        int idx2;
        logic [19:0] b1, b2;
        vc   = 0;
        idx2 = -1;
        b1   = 20'd0;
        b2   = 20'd0;
        @(negedge clock);
        value = 32'd12;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                vc++;
                if (vc == 1) b1 = bcd;
                if (vc == 2) begin b2 = bcd; idx2 = i; end
            end
            if (i == 5) value = 32'd34;
        end
        checks++; if (vc !== 2) begin errors++; $display("FAIL change_valid_pulses: got %0d want 2", vc); end
        checks++; if (b1 !== 20'h00012) begin errors++; $display("FAIL change_first_bcd: got %h want %h", b1, 20'h00012); end
        checks++; if (b2 !== 20'h00034) begin errors++; $display("FAIL change_second_bcd: got %h want %h", b2, 20'h00034); end
        checks++; if (idx2 !== 36) begin errors++; $display("FAIL change_second_time: got %0d want 36", idx2); end
    endtask

    task automatic test_hold;
        int lat, bc, vc;
        logic [19:0] b;
        logic o, e;
        @(negedge clock);
        run_value(32'd34, 100, lat, bc, vc, b, o, e);
        checks++; if (vc !== 0) begin errors++; $display("FAIL hold_valid_pulses: got %0d want 0", vc); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL hold_busy_cycles: got %0d want 0", bc); end
        checks++; if (bcd !== 20'h00034) begin errors++; $display("FAIL hold_bcd: got %h want %h", bcd, 20'h00034); end
    endtask

    task automatic test_reset_mid;
        int vc;
        int lat, bc, vc2;
        logic [19:0] b;
        logic o, e;
        vc = 0;
        @(negedge clock);
        value = 32'd99;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (valid === 1'b1) vc++;
        end
        resetn = 1'b0;
        #1;
        checks++; if (bcd !== 20'd0) begin errors++; $display("FAIL rstmid_bcd: got %h want %h", bcd, 20'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (ovf !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ovf=%b valid=%b want 0 0", ovf, valid); end
        checks++; if (vc !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", vc); end
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        run_value(32'd99, 40, lat, bc, vc2, b, o, e);
        checks++; if (lat !== 18) begin errors++; $display("FAIL rstmid_latency: got %0d want 18", lat); end
        checks++; if (b !== 20'h00099) begin errors++; $display("FAIL rstmid_bcd_after: got %h want %h", b, 20'h00099); end
        checks++; if (vc2 !== 1) begin errors++; $display("FAIL rstmid_valid_after: got %0d want 1", vc2); end
    endtask

    initial begin
        resetn = 1'b0;
        value  = 32'd0;
        test_reset;
        test_basic;
        test_overflow;
        test_upper_bits;
        test_boundary;
        test_mid_change;
        test_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
